mem_stage: RTL

Memory-access stage of the five-stage MIPS pipeline, between the execute stage and write-back. It latches the execute stage's result bus, waits for the data-SRAM read response of a load (variable latency, valid-qualified), and buffers that response if write-back is stalled. It then forwards the final result, rf write enable and destination register to write-back using the standard valid/allowin handshake.

---
 rtl/mem_stage.sv | 62 ++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: MIPS memory stage that latches the EX bus, waits for or buffers the load response, then hands off to WB; defining MS_FWD_EN drives ms_to_ds_fwd_bus
`ifndef ES_TO_MS_BUS_WD
`define ES_TO_MS_BUS_WD 71
`endif
`ifndef MS_TO_WS_BUS_WD
`define MS_TO_WS_BUS_WD 70
`endif
module mem_stage (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ws_allowin,
  output logic                        ms_allowin,
  input  logic                        es_to_ms_valid,
  input  logic [`ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                        ms_to_ws_valid,
  output logic [`MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic [31:0]                 data_sram_rdata,
  input  logic                        data_sram_rvalid,
  output logic [38:0]                 ms_to_ds_fwd_bus,
  output logic [31:0]                 ms_stall_cnt
);
  logic                        ms_valid;
  logic [`ES_TO_MS_BUS_WD-1:0] ms_bus;
  logic                        rdata_got;
  logic [31:0]                 rdata_buf;
  logic [31:0]                 ms_pc;
  logic                        ms_load_op;
  logic                        ms_rf_we;
  logic [4:0]                  ms_rf_waddr;
  logic [31:0]                 ms_alu_result;
  logic                        ms_ready_go;
  logic [31:0]                 final_result;
  assign {ms_pc, ms_load_op, ms_rf_we, ms_rf_waddr, ms_alu_result} = ms_bus;
  assign ms_ready_go    = ~ms_load_op | rdata_got | data_sram_rvalid;
  assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid & ms_ready_go;
  assign final_result   = ~ms_load_op ? ms_alu_result : rdata_got ? rdata_buf : data_sram_rdata;
  assign ms_to_ws_bus   = {ms_pc, ms_rf_we, ms_rf_waddr, final_result};
`ifdef MS_FWD_EN
  assign ms_to_ds_fwd_bus = {ms_valid & ms_rf_we, ms_rf_waddr, ms_ready_go, final_result};
`else
  assign ms_to_ds_fwd_bus = '0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid     <= 1'b0;
      ms_bus       <= '0;
      rdata_got    <= 1'b0;
      rdata_buf    <= '0;
      ms_stall_cnt <= '0;
    end else begin
      if (ms_allowin) ms_valid <= es_to_ms_valid;
      if (ms_allowin & es_to_ms_valid) ms_bus <= es_to_ms_bus;
      if (ms_to_ws_valid & ws_allowin) rdata_got <= 1'b0;
      else if (ms_valid & ms_load_op & ~rdata_got & data_sram_rvalid & ~ws_allowin) begin
        rdata_got <= 1'b1;
        rdata_buf <= data_sram_rdata;
      end
      if (ms_valid & ~ms_ready_go & ~&ms_stall_cnt) ms_stall_cnt <= ms_stall_cnt + 32'd1;
    end
  end
endmodule
